// File: rtl/pipelined_addsub.sv
// Chunked carry-pipelined adder/subtractor with valid/ready backpressure,
// registered zero/carry/overflow flags and a saturating overflow counter.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int NCHUNK = 4,
  parameter int SWIDTH = WIDTH + 1,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic              cin,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SWIDTH-1:0] sm,
  output logic              sm_zero,
  output logic              sm_carry,
  output logic              sm_ovf,
  input  logic              clr_cnt,
  output logic [CNTW-1:0]   ovf_cnt
);

  localparam int CW   = WIDTH / NCHUNK;
  localparam int LAST = NCHUNK - 1;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
  endfunction

  logic advance;

  // Per-stage pipeline registers: operands travel full width (upper chunks
  // are the skew path), r_p carries finished lower chunks (de-skew path).
  logic             vld_p [NCHUNK];
  logic             cy_p  [NCHUNK];
  logic             sub_p [NCHUNK];
  logic [WIDTH-1:0] a_p   [NCHUNK];
  logic [WIDTH-1:0] b_p   [NCHUNK];
  logic [WIDTH-1:0] r_p   [NCHUNK];

  logic             vld_i [NCHUNK];
  logic             cy_i  [NCHUNK];
  logic             sub_i [NCHUNK];
  logic [WIDTH-1:0] a_i   [NCHUNK];
  logic [WIDTH-1:0] b_i   [NCHUNK];
  logic [WIDTH-1:0] r_i   [NCHUNK];
  logic [CW:0]      sum_n [NCHUNK];
  logic [WIDTH-1:0] r_n   [NCHUNK];
  logic             zero_n;
  logic             carry_n;
  logic             ovf_n;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p[LAST];

  always_comb begin
    // Subtract is x + ~y + ~cin; the carry-out is inverted into a borrow later.
    vld_i[0] = in_valid;
    cy_i[0]  = cin ^ op_sub;
    sub_i[0] = op_sub;
    a_i[0]   = x;
    b_i[0]   = y ^ {WIDTH{op_sub}};
    r_i[0]   = '0;
    for (int k = 1; k < NCHUNK; k++) begin
      vld_i[k] = vld_p[k-1];
      cy_i[k]  = cy_p[k-1];
      sub_i[k] = sub_p[k-1];
      a_i[k]   = a_p[k-1];
      b_i[k]   = b_p[k-1];
      r_i[k]   = r_p[k-1];
    end
    for (int k = 0; k < NCHUNK; k++) begin
      sum_n[k] = {1'b0, a_i[k][k*CW +: CW]} + {1'b0, b_i[k][k*CW +: CW]}
               + {{CW{1'b0}}, cy_i[k]};
      r_n[k]   = r_i[k];
      r_n[k][k*CW +: CW] = sum_n[k][CW-1:0];
    end
    // Final stage: b already holds ~y for subtract, so one overflow rule serves both.
    zero_n  = (r_n[LAST] == '0);
    carry_n = sum_n[LAST][CW] ^ sub_i[LAST];
    ovf_n   = (a_i[LAST][WIDTH-1] == b_i[LAST][WIDTH-1]) &&
              (r_n[LAST][WIDTH-1] != a_i[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCHUNK; k++) begin
        vld_p[k] <= 1'b0;
        cy_p[k]  <= 1'b0;
        sub_p[k] <= 1'b0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        r_p[k]   <= '0;
      end
      sm       <= '0;
      sm_zero  <= 1'b0;
      sm_carry <= 1'b0;
      sm_ovf   <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < NCHUNK; k++) begin
        vld_p[k] <= vld_i[k];
        cy_p[k]  <= sum_n[k][CW];
        sub_p[k] <= sub_i[k];
        a_p[k]   <= a_i[k];
        b_p[k]   <= b_i[k];
        r_p[k]   <= r_n[k];
      end
      sm       <= {carry_n, r_n[LAST]};
      sm_zero  <= zero_n;
      sm_carry <= carry_n;
      sm_ovf   <= ovf_n;
    end
  end

  // Output transfer stage: count delivered overflowing results, clear wins.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && sm_ovf) begin
      ovf_cnt <= sat_inc(ovf_cnt);
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: a 32-bit/4-chunk instance and an
// 8-bit/2-chunk instance with a 2-bit overflow counter.
module tb_pipelined_addsub;

  typedef struct {
    logic [32:0] sm;
    logic        zero;
    logic        carry;
    logic        ovf;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        d1_in_valid = 1'b0, d1_op_sub = 1'b0, d1_cin = 1'b0;
  logic        d1_out_ready = 1'b1, d1_clr_cnt = 1'b0;
  logic [31:0] d1_x = '0, d1_y = '0;
  logic        d1_in_ready, d1_out_valid, d1_sm_zero, d1_sm_carry, d1_sm_ovf;
  logic [32:0] d1_sm;
  logic [7:0]  d1_ovf_cnt;

  logic        d2_in_valid = 1'b0, d2_op_sub = 1'b0, d2_cin = 1'b0;
  logic        d2_out_ready = 1'b1, d2_clr_cnt = 1'b0;
  logic [7:0]  d2_x = '0, d2_y = '0;
  logic        d2_in_ready, d2_out_valid, d2_sm_zero, d2_sm_carry, d2_sm_ovf;
  logic [8:0]  d2_sm;
  logic [1:0]  d2_ovf_cnt;

  pipelined_addsub #(.WIDTH(32), .NCHUNK(4), .CNTW(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .op_sub(d1_op_sub), .cin(d1_cin), .x(d1_x), .y(d1_y),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .sm(d1_sm),
    .sm_zero(d1_sm_zero), .sm_carry(d1_sm_carry), .sm_ovf(d1_sm_ovf),
    .clr_cnt(d1_clr_cnt), .ovf_cnt(d1_ovf_cnt));

  pipelined_addsub #(.WIDTH(8), .NCHUNK(2), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .op_sub(d2_op_sub), .cin(d2_cin), .x(d2_x), .y(d2_y),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .sm(d2_sm),
    .sm_zero(d2_sm_zero), .sm_carry(d2_sm_carry), .sm_ovf(d2_sm_ovf),
    .clr_cnt(d2_clr_cnt), .ovf_cnt(d2_ovf_cnt));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;
  bit lat_chk = 1'b0;

  exp_t q1[$];
  exp_t q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input bit s, input bit c,
                                 input longint unsigned a, input longint unsigned b,
                                 input int t);
    exp_t e;
    longint unsigned m, r, ci;
    longint sa, sb, sr, half;
    m    = 64'd1 << w;
    ci   = c ? 64'd1 : 64'd0;
    half = $signed(m >> 1);
    r    = s ? (a + (m << 1) - b - ci) % (m << 1) : a + b + ci;
    sa   = (a >= (m >> 1)) ? $signed(a) - $signed(m) : $signed(a);
    sb   = (b >= (m >> 1)) ? $signed(b) - $signed(m) : $signed(b);
    sr   = s ? sa - sb - $signed(ci) : sa + sb + $signed(ci);
    e.sm    = r[32:0];
    e.zero  = ((r % m) == 64'd0);
    e.carry = (((r / m) % 64'd2) == 64'd1);
    e.ovf   = (sr < -half) || (sr > half - 64'sd1);
    e.t     = t;
    return e;
  endfunction

  exp_t e1, e2;
  int   ecnt1 = 0, ecnt2 = 0;
  bit   stall1 = 1'b0, stall2 = 1'b0, xovf1, xovf2;
  logic [32:0] psm1;
  logic [8:0]  psm2;

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      ecnt1  = 0;
      stall1 = 1'b0;
    end else begin
      chk("d1_ovf_cnt", 64'(d1_ovf_cnt), 64'(ecnt1));
      if (stall1) begin
        chk("d1_hold_valid", 64'(d1_out_valid), 64'd1);
        chk("d1_hold_sm", 64'(d1_sm), 64'(psm1));
      end
      xovf1 = 1'b0;
      if (d1_out_valid && d1_out_ready) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d1_unexpected_result actual=%0h required=none", d1_sm);
        end else begin
          e1 = q1.pop_front();
          chk("d1_sm", 64'(d1_sm), 64'(e1.sm));
          chk("d1_zero", 64'(d1_sm_zero), 64'(e1.zero));
          chk("d1_carry", 64'(d1_sm_carry), 64'(e1.carry));
          chk("d1_ovf", 64'(d1_sm_ovf), 64'(e1.ovf));
          if (lat_chk) chk("d1_latency", 64'(cyc - e1.t), 64'd4);
          xovf1 = e1.ovf;
        end
      end
      if (d1_clr_cnt) ecnt1 = 0;
      else if (xovf1 && ecnt1 < 255) ecnt1++;
      stall1 = d1_out_valid && !d1_out_ready;
      psm1   = d1_sm;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q2.delete();
      ecnt2  = 0;
      stall2 = 1'b0;
    end else begin
      chk("d2_ovf_cnt", 64'(d2_ovf_cnt), 64'(ecnt2));
      if (stall2) begin
        chk("d2_hold_valid", 64'(d2_out_valid), 64'd1);
        chk("d2_hold_sm", 64'(d2_sm), 64'(psm2));
      end
      xovf2 = 1'b0;
      if (d2_out_valid && d2_out_ready) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d2_unexpected_result actual=%0h required=none", d2_sm);
        end else begin
          e2 = q2.pop_front();
          chk("d2_sm", 64'(d2_sm), 64'(e2.sm));
          chk("d2_zero", 64'(d2_sm_zero), 64'(e2.zero));
          chk("d2_carry", 64'(d2_sm_carry), 64'(e2.carry));
          chk("d2_ovf", 64'(d2_sm_ovf), 64'(e2.ovf));
          if (lat_chk) chk("d2_latency", 64'(cyc - e2.t), 64'd2);
          xovf2 = e2.ovf;
        end
      end
      if (d2_clr_cnt) ecnt2 = 0;
      else if (xovf2 && ecnt2 < 3) ecnt2++;
      stall2 = d2_out_valid && !d2_out_ready;
      psm2   = d2_sm;
    end
  end

  task automatic send1(input bit s, input bit c, input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    d1_in_valid = 1'b1; d1_op_sub = s; d1_cin = c; d1_x = a; d1_y = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      d1_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (d1_in_ready) begin
        q1.push_back(model(32, s, c, 64'(a), 64'(b), cyc));
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    d1_in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL d1_accept actual=stalled required=accepted");
    end
  endtask

  task automatic send2(input bit s, input bit c, input logic [7:0] a, input logic [7:0] b);
    bit ok = 1'b0;
    d2_in_valid = 1'b1; d2_op_sub = s; d2_cin = c; d2_x = a; d2_y = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      d2_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (d2_in_ready) begin
        q2.push_back(model(8, s, c, 64'(a), 64'(b), cyc));
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    d2_in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL d2_accept actual=stalled required=accepted");
    end
  endtask

  task automatic drain();
    d1_out_ready = 1'b1;
    d2_out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_pending", 64'(q1.size() + q2.size()), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_d1_out_valid", 64'(d1_out_valid), 64'd0);
    chk("rst_d1_in_ready", 64'(d1_in_ready), 64'd1);
    chk("rst_d1_sm", 64'(d1_sm), 64'd0);
    chk("rst_d1_flags", 64'({d1_sm_zero, d1_sm_carry, d1_sm_ovf}), 64'd0);
    chk("rst_d2_out_valid", 64'(d2_out_valid), 64'd0);
    chk("rst_d2_in_ready", 64'(d2_in_ready), 64'd1);
    chk("rst_d2_sm", 64'(d2_sm), 64'd0);
    @(posedge clk); #1;

    // Directed boundary cases, unstalled so latency is checked exactly.
    lat_chk = 1'b1;
    rand_rdy = 1'b0;
    send1(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    send1(1'b1, 1'b0, 32'd5, 32'd7);
    send1(1'b1, 1'b1, 32'd7, 32'd5);
    send1(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    send1(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001);
    send1(1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678);
    drain();
    chk("d1_ovf_cnt_two", 64'(d1_ovf_cnt), 64'd2);

    // Random streaming under pseudo-random backpressure.
    lat_chk = 1'b0;
    rand_rdy = 1'b1;
    repeat (20) send1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    rand_rdy = 1'b0;
    drain();

    // Back-to-back with out_ready held high: one result per cycle at fixed latency.
    lat_chk = 1'b1;
    repeat (10) send1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    drain();

    // Reset with three beats in flight.
    send1(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1);
    send1(1'b1, 1'b0, 32'h8000_0000, 32'h1);
    send1(1'b0, 1'b1, 32'h1, 32'h2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(d1_out_valid), 64'd0);
    chk("midrst_ovf_cnt", 64'(d1_ovf_cnt), 64'd0);
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end

    // Small instance: counter saturation, then clear racing an overflow transfer.
    repeat (5) send2(1'b0, 1'b0, 8'h7F, 8'h01);
    drain();
    chk("d2_ovf_cnt_sat", 64'(d2_ovf_cnt), 64'd3);
    send2(1'b0, 1'b0, 8'h7F, 8'h01);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (d2_out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("d2_result_seen", 64'(seen), 64'd1);
    d2_clr_cnt = 1'b1;
    @(posedge clk); #1;
    d2_clr_cnt = 1'b0;
    @(negedge clk);
    chk("d2_clr_priority", 64'(d2_ovf_cnt), 64'd0);
    @(posedge clk); #1;

    lat_chk = 1'b0;
    rand_rdy = 1'b1;
    repeat (15) send2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    rand_rdy = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
